// File: rtl/serv_debug_ctrl.sv
// Debug-mode entry/exit sequencer for the bit-serial SERV core.
// Streams PC into dpc on entry, redirects fetch to the debug ROM, and returns to dpc on dret.
module serv_debug_ctrl #(
    parameter int          W            = 1,
    parameter logic [31:0] DM_HALT_ADDR = 32'h00000800
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_haltreq,
    input  logic         i_insn_done,
    input  logic         i_ebreak,
    input  logic         i_dret,
    input  logic         i_dcsr_step,
    input  logic         i_dcsr_ebreakm,
    output logic         o_stall,
    output logic         o_dpc_en,
    output logic [1:0]   o_pc_sel,
    output logic [W-1:0] o_pc_data,
    output logic         o_dbg_mode,
    output logic [2:0]   o_cause,
    output logic         o_irq_mask,
    output logic         o_resume_ack
);

    localparam int             NBEATS   = 32 / W;
    localparam int             CW       = $clog2(NBEATS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(NBEATS - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_ENTER  = 3'd1,
        ST_REDIR  = 3'd2,
        ST_DEBUG  = 3'd3,
        ST_RESUME = 3'd4
    } state_t;

    state_t         state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic           step_pend_r, step_pend_s;
    logic [2:0]     cause_r, cause_s;
    logic           ack_s;
    logic           cnt_last_s;

    logic           stall_r, stall_s;
    logic           dpc_en_r, dpc_en_s;
    logic [1:0]     pc_sel_r, pc_sel_s;
    logic [W-1:0]   pc_data_r, pc_data_s;
    logic           dbg_mode_r, dbg_mode_s;
    logic           irq_mask_r, irq_mask_s;
    logic           resume_ack_r;

    function automatic logic [W-1:0] halt_beat(input logic [CW-1:0] beat);
        return DM_HALT_ADDR[int'(beat) * W +: W];
    endfunction

    assign cnt_last_s = (cnt_r == CNT_LAST);

    // Next-state, counter, trigger latching and step bookkeeping
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        step_pend_s = step_pend_r;
        cause_s     = cause_r;
        ack_s       = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (i_insn_done && i_ebreak && i_dcsr_ebreakm) begin
                    cause_s     = 3'd1;
                    state_s     = ST_ENTER;
                    cnt_s       = '0;
                    step_pend_s = 1'b0;
                end else if (i_insn_done && i_haltreq) begin
                    cause_s     = 3'd3;
                    state_s     = ST_ENTER;
                    cnt_s       = '0;
                    step_pend_s = 1'b0;
                end else if (i_insn_done && step_pend_r) begin
                    cause_s     = 3'd4;
                    state_s     = ST_ENTER;
                    cnt_s       = '0;
                    step_pend_s = 1'b0;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_ENTER: begin
                if (cnt_last_s) begin
                    state_s = ST_REDIR;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_REDIR: begin
                if (cnt_last_s) begin
                    state_s = ST_DEBUG;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DEBUG: begin
                // dpc and cause are left alone on a nested ebreak: only fetch is redirected
                if (i_insn_done && i_dret) begin
                    state_s = ST_RESUME;
                    cnt_s   = '0;
                end else if (i_insn_done && i_ebreak) begin
                    state_s = ST_REDIR;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_DEBUG;
                end
            end
            ST_RESUME: begin
                if (cnt_last_s) begin
                    state_s     = ST_RUN;
                    cnt_s       = '0;
                    step_pend_s = i_dcsr_step;
                    ack_s       = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs can be registered without extra latency
    always_comb begin
        stall_s    = 1'b0;
        dpc_en_s   = 1'b0;
        pc_sel_s   = 2'd0;
        pc_data_s  = '0;
        dbg_mode_s = 1'b0;
        case (state_s)
            ST_RUN: begin
                stall_s = 1'b0;
            end
            ST_ENTER: begin
                stall_s  = 1'b1;
                dpc_en_s = 1'b1;
            end
            ST_REDIR: begin
                stall_s    = 1'b1;
                pc_sel_s   = 2'd1;
                pc_data_s  = halt_beat(cnt_s);
                dbg_mode_s = 1'b1;
            end
            ST_DEBUG: begin
                dbg_mode_s = 1'b1;
            end
            ST_RESUME: begin
                stall_s    = 1'b1;
                pc_sel_s   = 2'd2;
                dbg_mode_s = 1'b1;
            end
            default: begin
                stall_s = 1'b0;
            end
        endcase
        irq_mask_s = dbg_mode_s | step_pend_s | (state_s == ST_ENTER);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r      <= ST_RUN;
            cnt_r        <= '0;
            step_pend_r  <= 1'b0;
            cause_r      <= 3'd0;
            stall_r      <= 1'b0;
            dpc_en_r     <= 1'b0;
            pc_sel_r     <= 2'd0;
            pc_data_r    <= '0;
            dbg_mode_r   <= 1'b0;
            irq_mask_r   <= 1'b0;
            resume_ack_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            step_pend_r  <= step_pend_s;
            cause_r      <= cause_s;
            stall_r      <= stall_s;
            dpc_en_r     <= dpc_en_s;
            pc_sel_r     <= pc_sel_s;
            pc_data_r    <= pc_data_s;
            dbg_mode_r   <= dbg_mode_s;
            irq_mask_r   <= irq_mask_s;
            resume_ack_r <= ack_s;
        end
    end

    assign o_stall      = stall_r;
    assign o_dpc_en     = dpc_en_r;
    assign o_pc_sel     = pc_sel_r;
    assign o_pc_data    = pc_data_r;
    assign o_dbg_mode   = dbg_mode_r;
    assign o_cause      = cause_r;
    assign o_irq_mask   = irq_mask_r;
    assign o_resume_ack = resume_ack_r;

    // A retire while issue is stalled means the core ignored o_stall
    property p_no_retire_when_stalled;
        @(posedge clk) disable iff (i_rst)
            !(i_insn_done && (state_r == ST_ENTER || state_r == ST_REDIR || state_r == ST_RESUME));
    endproperty
    a_no_retire_when_stalled: assert property (p_no_retire_when_stalled);

endmodule

// File: tb/tb_serv_debug_ctrl.sv
// Directed scoreboard bench for serv_debug_ctrl, W=1 and W=4 instances.
module tb_serv_debug_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, halt1, insn1, ebrk1, dret1, step1, ebm1;
    logic       stall1, dpc1, dbg1, irq1, ack1;
    logic [1:0] sel1;
    logic [0:0] data1;
    logic [2:0] cause1;

    logic       rst4, halt4, insn4, ebrk4, dret4, step4, ebm4;
    logic       stall4, dpc4, dbg4, irq4, ack4;
    logic [1:0] sel4;
    logic [3:0] data4;
    logic [2:0] cause4;

    serv_debug_ctrl #(.W(1), .DM_HALT_ADDR(32'h00000800)) dut1 (
        .clk(clk), .i_rst(rst1), .i_haltreq(halt1), .i_insn_done(insn1),
        .i_ebreak(ebrk1), .i_dret(dret1), .i_dcsr_step(step1), .i_dcsr_ebreakm(ebm1),
        .o_stall(stall1), .o_dpc_en(dpc1), .o_pc_sel(sel1), .o_pc_data(data1),
        .o_dbg_mode(dbg1), .o_cause(cause1), .o_irq_mask(irq1), .o_resume_ack(ack1)
    );

    serv_debug_ctrl #(.W(4), .DM_HALT_ADDR(32'h00000800)) dut4 (
        .clk(clk), .i_rst(rst4), .i_haltreq(halt4), .i_insn_done(insn4),
        .i_ebreak(ebrk4), .i_dret(dret4), .i_dcsr_step(step4), .i_dcsr_ebreakm(ebm4),
        .o_stall(stall4), .o_dpc_en(dpc4), .o_pc_sel(sel4), .o_pc_data(data4),
        .o_dbg_mode(dbg4), .o_cause(cause4), .o_irq_mask(irq4), .o_resume_ack(ack4)
    );

    // {stall, dpc_en, pc_sel, pc_data(4), dbg_mode, irq_mask, resume_ack, cause}
    logic [13:0] act1, act4;
    assign act1 = {stall1, dpc1, sel1, 3'b000, data1, dbg1, irq1, ack1, cause1};
    assign act4 = {stall4, dpc4, sel4, data4, dbg4, irq4, ack4, cause4};

    logic [13:0] exp_q[$];
    bit          dut_q[$];
    string       tag_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic [13:0] mk(input bit stall, input bit dpc, input logic [1:0] sel,
                                       input logic [3:0] data, input bit dbg, input bit irq,
                                       input bit ack, input logic [2:0] cause);
        return {stall, dpc, sel, data, dbg, irq, ack, cause};
    endfunction

    function automatic logic [3:0] beat(input bit d4, input int i);
        logic [31:0] addr;
        addr = 32'h00000800;
        if (d4) return 4'((addr >> (i * 4)) & 32'h0000000F);
        else    return 4'((addr >> i) & 32'h00000001);
    endfunction

    task automatic push(input bit d4, input logic [13:0] v, input string tag);
        exp_q.push_back(v);
        dut_q.push_back(d4);
        tag_q.push_back(tag);
    endtask

    task automatic tick();
        logic [13:0] e, a;
        bit          d;
        string       t;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            d = dut_q.pop_front();
            t = tag_q.pop_front();
            a = d ? act4 : act1;
            vectors++;
            assert (a === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", t, a, e);
            end
        end
    endtask

    task automatic retire(input bit d4, input bit eb, input bit dr, input logic [13:0] v,
                          input string tag);
        if (d4) begin insn4 = 1'b1; ebrk4 = eb; dret4 = dr; end
        else    begin insn1 = 1'b1; ebrk1 = eb; dret1 = dr; end
        push(d4, v, tag);
        tick();
        insn1 = 1'b0; ebrk1 = 1'b0; dret1 = 1'b0;
        insn4 = 1'b0; ebrk4 = 1'b0; dret4 = 1'b0;
    endtask

    task automatic enter_rest(input bit d4, input logic [2:0] cause);
        int n;
        n = d4 ? 8 : 32;
        for (int i = 1; i < n; i++) begin
            push(d4, mk(1, 1, 2'd0, 4'd0, 0, 1, 0, cause), "enter_dpc");
            tick();
        end
    endtask

    task automatic redir(input bit d4, input logic [2:0] cause, input int start);
        int n;
        n = d4 ? 8 : 32;
        for (int i = start; i < n; i++) begin
            push(d4, mk(1, 0, 2'd1, beat(d4, i), 1, 1, 0, cause), "redir_halt_addr");
            tick();
        end
        push(d4, mk(0, 0, 2'd0, 4'd0, 1, 1, 0, cause), "debug_mode");
        tick();
    endtask

    task automatic resume(input bit d4, input logic [2:0] cause, input bit stepflag);
        int n;
        n = d4 ? 8 : 32;
        retire(d4, 1'b0, 1'b1, mk(1, 0, 2'd2, 4'd0, 1, 1, 0, cause), "resume_first");
        for (int i = 1; i < n; i++) begin
            push(d4, mk(1, 0, 2'd2, 4'd0, 1, 1, 0, cause), "resume_dpc");
            tick();
        end
        push(d4, mk(0, 0, 2'd0, 4'd0, 0, stepflag, 1, cause), "resume_ack");
        tick();
        push(d4, mk(0, 0, 2'd0, 4'd0, 0, stepflag, 0, cause), "run_after_ack");
        tick();
    endtask

    initial begin
        rst1 = 1'b1; halt1 = 1'b0; insn1 = 1'b0; ebrk1 = 1'b0; dret1 = 1'b0; step1 = 1'b0; ebm1 = 1'b0;
        rst4 = 1'b1; halt4 = 1'b0; insn4 = 1'b0; ebrk4 = 1'b0; dret4 = 1'b0; step4 = 1'b0; ebm4 = 1'b0;
        push(1'b0, 14'd0, "reset_w1");
        tick();
        push(1'b1, 14'd0, "reset_w4");
        tick();
        rst1 = 1'b0; rst4 = 1'b0;
        push(1'b0, 14'd0, "idle_run");
        tick();

        // haltreq entry, haltreq ignored while in DEBUG, then dret
        halt1 = 1'b1;
        retire(1'b0, 1'b0, 1'b0, mk(1, 1, 2'd0, 4'd0, 0, 1, 0, 3'd3), "haltreq_enter");
        enter_rest(1'b0, 3'd3);
        redir(1'b0, 3'd3, 0);
        push(1'b0, mk(0, 0, 2'd0, 4'd0, 1, 1, 0, 3'd3), "debug_haltreq_ignored");
        tick();
        halt1 = 1'b0;
        resume(1'b0, 3'd3, 1'b0);

        // ebreak beats haltreq; nested ebreak in DEBUG; resume with single-step
        ebm1 = 1'b1; halt1 = 1'b1;
        retire(1'b0, 1'b1, 1'b0, mk(1, 1, 2'd0, 4'd0, 0, 1, 0, 3'd1), "ebreak_priority");
        halt1 = 1'b0;
        enter_rest(1'b0, 3'd1);
        redir(1'b0, 3'd1, 0);
        retire(1'b0, 1'b1, 1'b0, mk(1, 0, 2'd1, beat(1'b0, 0), 1, 1, 0, 3'd1), "ebreak_in_debug");
        redir(1'b0, 3'd1, 1);
        step1 = 1'b1;
        resume(1'b0, 3'd1, 1'b1);
        push(1'b0, mk(0, 0, 2'd0, 4'd0, 0, 1, 0, 3'd1), "step_pend_wait");
        tick();
        retire(1'b0, 1'b0, 1'b0, mk(1, 1, 2'd0, 4'd0, 0, 1, 0, 3'd4), "step_enter");
        step1 = 1'b0;
        enter_rest(1'b0, 3'd4);
        redir(1'b0, 3'd4, 0);
        resume(1'b0, 3'd4, 1'b0);

        // ebreak without ebreakm and dret in RUN are not debug events
        ebm1 = 1'b0;
        retire(1'b0, 1'b1, 1'b0, mk(0, 0, 2'd0, 4'd0, 0, 0, 0, 3'd4), "ebreak_no_ebreakm");
        retire(1'b0, 1'b0, 1'b1, mk(0, 0, 2'd0, 4'd0, 0, 0, 0, 3'd4), "dret_in_run");

        // synchronous reset in the middle of ENTER (cnt=10)
        halt1 = 1'b1;
        retire(1'b0, 1'b0, 1'b0, mk(1, 1, 2'd0, 4'd0, 0, 1, 0, 3'd3), "enter_before_rst");
        for (int i = 1; i <= 10; i++) begin
            push(1'b0, mk(1, 1, 2'd0, 4'd0, 0, 1, 0, 3'd3), "enter_before_rst");
            tick();
        end
        rst1 = 1'b1; halt1 = 1'b0;
        push(1'b0, 14'd0, "rst_mid_enter");
        tick();
        rst1 = 1'b0;
        retire(1'b0, 1'b0, 1'b0, 14'd0, "run_after_rst");

        // W=4: 8-cycle transfers, halt address in nibbles
        halt4 = 1'b1;
        retire(1'b1, 1'b0, 1'b0, mk(1, 1, 2'd0, 4'd0, 0, 1, 0, 3'd3), "w4_enter");
        halt4 = 1'b0;
        enter_rest(1'b1, 3'd3);
        redir(1'b1, 3'd3, 0);
        resume(1'b1, 3'd3, 1'b0);

        if (exp_q.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_drain: observed %0d entries left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serv_debug_ctrl.md
Name: serv_debug_ctrl

Overview:
Sequences RISC-V debug-mode entry and exit for the bit-serial SERV core. The block watches instruction-retire boundaries for haltreq, ebreak (dcsr.ebreakm set) and single-step, and stalls issue while entering or leaving debug mode. During entry it streams the PC into dpc serially, then redirects fetch to the debug-ROM halt address; on dret it redirects fetch back to dpc. It sits between the decoder (ebreak/dret flags), the CSR block (dcsr step/ebreakm, dpc write enable) and ctrl (PC source select).

Parameters:
W, 1, serial datapath width in bits per cycle (1, 2 or 4); one transfer = 32/W cycles
DM_HALT_ADDR, 32'h00000800, debug-ROM entry address streamed to ctrl on entry

Ports:
clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_haltreq  in  1  debug-module halt request, level
i_insn_done  in  1  one-cycle strobe at instruction retire
i_ebreak  in  1  retiring instruction is ebreak (decoder)
i_dret  in  1  retiring instruction is dret (decoder)
i_dcsr_step  in  1  dcsr.step
i_dcsr_ebreakm  in  1  dcsr.ebreakm
o_stall  out  1  hold fetch/issue
o_dpc_en  out  1  serial write enable for dpc (source = current PC)
o_pc_sel  out  2  0 normal, 1 halt address (o_pc_data), 2 dpc
o_pc_data  out  W  serial halt-address bits, LSB first
o_dbg_mode  out  1  hart in debug mode
o_cause  out  3  dcsr.cause: 1 ebreak, 3 haltreq, 4 step
o_irq_mask  out  1  mask interrupts
o_resume_ack  out  1  one-cycle pulse on return to RUN

Behaviour:
- States: RUN, ENTER, REDIR, DEBUG, RESUME. Counter cnt, width clog2(32/W).
- Reset: state RUN, cnt 0, step_pend 0. All outputs 0 (o_pc_sel 0, o_cause 0). Reset mid-transfer aborts immediately; no partial-state recovery.
- RUN: triggers evaluated only when i_insn_done is 1, with priority ebreak (i_ebreak & i_dcsr_ebreakm) > haltreq > step_pend.
  - Any trigger: latch o_cause (1/3/4), clear step_pend, go to ENTER with cnt=0.
  - An ebreak with ebreakm=0 is not handled here; it is a normal trap.
- ENTER: o_stall=1, o_dpc_en=1, cnt increments each cycle. At cnt=32/W-1, go to REDIR with cnt=0.
- REDIR: o_stall=1, o_pc_sel=1, o_pc_data=DM_HALT_ADDR[cnt*W +: W]. At the last cnt, go to DEBUG.
- DEBUG: o_dbg_mode=1, o_irq_mask=1, o_stall=0; the debug ROM executes.
  - i_insn_done & i_dret: go to RESUME, cnt=0.
  - i_insn_done & i_ebreak: go to REDIR. dpc and o_cause are unchanged.
  - i_haltreq is ignored.
- RESUME: o_stall=1, o_pc_sel=2, o_dbg_mode=1, for 32/W cycles.
  - On the last cycle, sample i_dcsr_step into step_pend, go to RUN, and pulse o_resume_ack the following cycle.
- o_dbg_mode is 1 in REDIR, DEBUG and RESUME; 0 in RUN and ENTER.
- o_irq_mask = o_dbg_mode | step_pend | (state==ENTER).
- o_cause holds its value until the next entry.
- i_insn_done in ENTER, REDIR or RESUME is ignored and flagged as a protocol error in simulation.
- A haltreq still held after resume re-enters only after one instruction retires, so forward progress is guaranteed.
- An i_dret retired in RUN is ignored.
- Entry latency from the i_insn_done strobe to the first o_pc_sel=1 cycle: 1 + 32/W cycles.

Test Plan:
- W=1, haltreq held, i_insn_done strobe: o_dpc_en high exactly 32 cycles, then o_pc_sel=1 for 32 cycles with bits 0x800 LSB-first. o_cause=3, o_dbg_mode=1.
- In DEBUG, retire dret: o_pc_sel=2 for 32 cycles, state RUN, o_resume_ack a 1-cycle pulse, o_dbg_mode=0.
- ebreak + ebreakm=1 with haltreq=1 at the same retire: o_cause=1.
- Same with ebreakm=0 and haltreq=0: stays in RUN.
- Resume with dcsr.step=1: exactly one i_insn_done later, ENTER with o_cause=4. o_irq_mask high throughout.
- ebreak retired in DEBUG: REDIR again, o_dpc_en never asserts, o_cause unchanged.
- i_rst asserted at ENTER cnt=10: next cycle state RUN and all outputs 0. W=4 run: transfers are 8 cycles.
